// File: rtl/vga_pkg.sv
// Shared VGA constants, CRC parameters and the per-frame result record
// used by the stream monitor and its consumers.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef struct packed {
    logic [15:0] frame;
    logic [15:0] crc;
    logic [19:0] pix_cnt;
    logic [10:0] line_cnt;
    logic        coord_err;
    logic        size_err;
    logic        overrun;
  } frame_result_t;

endpackage

// File: rtl/vga_if.sv
// Pixel stream bundle passed between drawing stages.
interface vga_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/crc16_12b.sv
// Combinational CRC-16 update over one 12-bit RGB word, MSB first,
// unrolled as twelve serial LFSR steps.
module crc16_12b
  import vga_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] chain [0:12];

  assign chain[0] = crc_in;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_step
      logic fb;
      assign fb = chain[gi][15] ^ data[11-gi];
      assign chain[gi+1] = {chain[gi][14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  endgenerate

  assign crc_out = chain[12];

endmodule

// File: rtl/vga_frame_monitor.sv
// Taps a vga_if stream, measures each complete frame (pixel/line counts,
// CRC-16 of active RGB, coordinate consistency) and reports via valid/ready.
module vga_frame_monitor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = HOR_PIXELS,
  parameter int V_ACTIVE = VER_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [15:0] res_frame,
  output logic [15:0] res_crc,
  output logic [19:0] res_pix_cnt,
  output logic [10:0] res_line_cnt,
  output logic        res_coord_err,
  output logic        res_size_err,
  output logic        res_overrun
);

  localparam logic [0:0] ST_WAIT_START = 1'b0;
  localparam logic [0:0] ST_CAPTURE    = 1'b1;

  localparam logic [19:0] PIX_EXPECTED  = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [10:0] LINE_EXPECTED = 11'(V_ACTIVE);
  localparam logic [19:0] PIX_MAX       = '1;
  localparam logic [10:0] LINE_MAX      = '1;

  logic [10:0] vcount_q;
  logic        vsync_q;
  logic        vblnk_q;
  logic [10:0] hcount_q;
  logic        hsync_q;
  logic        hblnk_q;
  logic [11:0] rgb_q;
  logic        vblnk_qq;
  logic        active_q;
  logic        active_qq;
  logic        unused_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_q  <= '0;
      vsync_q   <= 1'b0;
      vblnk_q   <= 1'b0;
      hcount_q  <= '0;
      hsync_q   <= 1'b0;
      hblnk_q   <= 1'b0;
      rgb_q     <= '0;
      vblnk_qq  <= 1'b0;
      active_qq <= 1'b0;
    end else begin
      vcount_q  <= vga_in.vcount;
      vsync_q   <= vga_in.vsync;
      vblnk_q   <= vga_in.vblnk;
      hcount_q  <= vga_in.hcount;
      hsync_q   <= vga_in.hsync;
      hblnk_q   <= vga_in.hblnk;
      rgb_q     <= vga_in.rgb;
      vblnk_qq  <= vblnk_q;
      active_qq <= active_q;
    end
  end

  // Sync pulses are carried along with the stream but play no part in measurement.
  assign unused_sync = vsync_q ^ hsync_q;

  logic fs;
  logic fe;
  logic line_end;

  assign active_q = !hblnk_q && !vblnk_q;
  assign fs       = !vblnk_q && vblnk_qq;
  assign fe       = vblnk_q && !vblnk_qq;
  assign line_end = !active_q && active_qq;

  logic [0:0]  state_reg;
  logic [0:0]  state_next;
  logic [15:0] crc_reg;
  logic [15:0] crc_next;
  logic [19:0] pix_cnt_reg;
  logic [19:0] pix_cnt_next;
  logic [10:0] line_cnt_reg;
  logic [10:0] line_cnt_next;
  logic [10:0] col_cnt_reg;
  logic [10:0] col_cnt_next;
  logic        coord_err_reg;
  logic        coord_err_next;

  logic        start;
  logic        track;
  logic        publish;
  logic [15:0] crc_base;
  logic [19:0] pix_base;
  logic [10:0] line_base;
  logic [10:0] col_base;
  logic        coord_base;
  logic [15:0] crc_stepped;

  assign start   = (state_reg == ST_WAIT_START) && fs;
  assign track   = start || (state_reg == ST_CAPTURE);
  assign publish = (state_reg == ST_CAPTURE) && fe;

  // The frame-start cycle may already carry the first active pixel, so it
  // accumulates on top of freshly initialised values rather than waiting a cycle.
  assign crc_base   = start ? CRC16_INIT : crc_reg;
  assign pix_base   = start ? '0 : pix_cnt_reg;
  assign line_base  = start ? '0 : line_cnt_reg;
  assign col_base   = start ? '0 : col_cnt_reg;
  assign coord_base = start ? 1'b0 : coord_err_reg;

  crc16_12b u_crc (
    .crc_in  (crc_base),
    .data    (rgb_q),
    .crc_out (crc_stepped)
  );

  always_comb begin
    crc_next       = crc_base;
    pix_cnt_next   = pix_base;
    line_cnt_next  = line_base;
    col_cnt_next   = col_base;
    coord_err_next = coord_base;
    if (track) begin
      if (active_q) begin
        crc_next     = crc_stepped;
        pix_cnt_next = (pix_base == PIX_MAX) ? PIX_MAX : pix_base + 20'd1;
        col_cnt_next = col_base + 11'd1;
        if ((hcount_q != col_base) || (vcount_q != line_base)) begin
          coord_err_next = 1'b1;
        end
      end
      if (line_end) begin
        line_cnt_next = (line_base == LINE_MAX) ? LINE_MAX : line_base + 11'd1;
        col_cnt_next  = '0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_CAPTURE;
    end else if (publish) begin
      state_next = ST_WAIT_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_WAIT_START;
      crc_reg       <= CRC16_INIT;
      pix_cnt_reg   <= '0;
      line_cnt_reg  <= '0;
      col_cnt_reg   <= '0;
      coord_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      crc_reg       <= crc_next;
      pix_cnt_reg   <= pix_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      col_cnt_reg   <= col_cnt_next;
      coord_err_reg <= coord_err_next;
    end
  end

  frame_result_t res_reg;
  frame_result_t res_new;
  logic          res_valid_reg;
  logic [15:0]   frame_cnt_reg;

  // A result still waiting for the consumer when the next one lands is
  // flagged as overrun; one accepted in this very cycle is not.
  always_comb begin
    res_new.frame     = frame_cnt_reg;
    res_new.crc       = crc_next;
    res_new.pix_cnt   = pix_cnt_next;
    res_new.line_cnt  = line_cnt_next;
    res_new.coord_err = coord_err_next;
    res_new.size_err  = (pix_cnt_next != PIX_EXPECTED) || (line_cnt_next != LINE_EXPECTED);
    res_new.overrun   = res_valid_reg && !res_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg       <= '0;
      res_valid_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else if (publish) begin
      res_reg       <= res_new;
      res_valid_reg <= 1'b1;
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end else if (res_valid_reg && res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid     = res_valid_reg;
  assign res_frame     = res_reg.frame;
  assign res_crc       = res_reg.crc;
  assign res_pix_cnt   = res_reg.pix_cnt;
  assign res_line_cnt  = res_reg.line_cnt;
  assign res_coord_err = res_reg.coord_err;
  assign res_size_err  = res_reg.size_err;
  assign res_overrun   = res_reg.overrun;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench: small-raster stream generator, frame-level reference
// model compared every cycle, plus directed literal checks.
module tb_vga_frame_monitor;
  import vga_pkg::*;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int H_TOT = 12;
  localparam int V_TOT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        res_ready;
  logic        res_valid;
  logic [15:0] res_frame;
  logic [15:0] res_crc;
  logic [19:0] res_pix_cnt;
  logic [10:0] res_line_cnt;
  logic        res_coord_err;
  logic        res_size_err;
  logic        res_overrun;

  vga_if vif();

  vga_frame_monitor #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT)) dut (
    .clk           (clk),
    .rst           (rst),
    .vga_in        (vif),
    .res_ready     (res_ready),
    .res_valid     (res_valid),
    .res_frame     (res_frame),
    .res_crc       (res_crc),
    .res_pix_cnt   (res_pix_cnt),
    .res_line_cnt  (res_line_cnt),
    .res_coord_err (res_coord_err),
    .res_size_err  (res_size_err),
    .res_overrun   (res_overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic          m_init = 1'b0;
  logic          m_prev_vblnk, m_prev_active, m_capturing, m_pending, m_valid;
  logic [15:0]   m_frame_cnt;
  frame_result_t m_res, m_new;
  logic [11:0]   fr_rgb[$];
  int            fr_h[$], fr_v[$], fr_seg[$], fr_pos[$];
  int            m_seg, m_pos;

  function automatic frame_result_t summarize();
    frame_result_t r;
    logic [15:0] c;
    logic        cerr;
    c    = 16'hFFFF;
    cerr = 1'b0;
    foreach (fr_rgb[i]) begin
      c = crc_model(c, fr_rgb[i]);
      if (fr_h[i] != fr_pos[i] || fr_v[i] != fr_seg[i]) cerr = 1'b1;
    end
    r           = '0;
    r.crc       = c;
    r.pix_cnt   = 20'(fr_rgb.size());
    r.line_cnt  = 11'(m_seg + 1);
    r.coord_err = cerr;
    r.size_err  = (fr_rgb.size() != H_ACT * V_ACT) || (m_seg + 1 != V_ACT);
    return r;
  endfunction

  always @(posedge clk) begin
    logic vb, act;
    if (rst) begin
      m_init = 1'b1; m_prev_vblnk = 1'b0; m_prev_active = 1'b0;
      m_capturing = 1'b0; m_pending = 1'b0; m_valid = 1'b0;
      m_frame_cnt = '0; m_res = '0;
    end else if (m_init) begin
      if (m_pending) begin
        m_new.overrun = m_valid && !res_ready;
        m_new.frame   = m_frame_cnt;
        m_res         = m_new;
        m_valid       = 1'b1;
        m_frame_cnt++;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      m_pending = 1'b0;
      vb  = vif.vblnk;
      act = !vif.hblnk && !vif.vblnk;
      if (!m_capturing && !vb && m_prev_vblnk) begin
        m_capturing = 1'b1;
        fr_rgb.delete(); fr_h.delete(); fr_v.delete(); fr_seg.delete(); fr_pos.delete();
        m_seg = -1; m_pos = 0;
      end
      if (m_capturing) begin
        if (vb && !m_prev_vblnk) begin
          m_new       = summarize();
          m_pending   = 1'b1;
          m_capturing = 1'b0;
        end else if (act) begin
          if (!m_prev_active) begin m_seg++; m_pos = 0; end
          fr_rgb.push_back(vif.rgb); fr_h.push_back(int'(vif.hcount));
          fr_v.push_back(int'(vif.vcount)); fr_seg.push_back(m_seg); fr_pos.push_back(m_pos);
          m_pos++;
        end
      end
      m_prev_active = act;
      m_prev_vblnk  = vb;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("valid",     32'(res_valid),     32'(m_valid));
      check("frame",     32'(res_frame),     32'(m_res.frame));
      check("crc",       32'(res_crc),       32'(m_res.crc));
      check("pix_cnt",   32'(res_pix_cnt),   32'(m_res.pix_cnt));
      check("line_cnt",  32'(res_line_cnt),  32'(m_res.line_cnt));
      check("coord_err", 32'(res_coord_err), 32'(m_res.coord_err));
      check("size_err",  32'(res_size_err),  32'(m_res.size_err));
      check("overrun",   32'(res_overrun),   32'(m_res.overrun));
    end
  end

  // ---------------- accepted-result log ----------------
  frame_result_t acc_q[$];
  always @(posedge clk) begin
    frame_result_t r;
    if (!rst && res_valid && res_ready) begin
      r.frame = res_frame; r.crc = res_crc; r.pix_cnt = res_pix_cnt;
      r.line_cnt = res_line_cnt; r.coord_err = res_coord_err;
      r.size_err = res_size_err; r.overrun = res_overrun;
      acc_q.push_back(r);
      $display("result frame=%0d crc=%04h pix=%0d lines=%0d coord=%0b size=%0b ovr=%0b",
               r.frame, r.crc, r.pix_cnt, r.line_cnt, r.coord_err, r.size_err, r.overrun);
    end
  end

  // ---------------- stimulus ----------------
  logic rand_ready = 1'b0;

  // mode 0 zeros, 1 ramp, 2 ramp with (3,2)=7, 3 hcount stuck at (5,1),
  // 4 line 2 short, 5 random rgb, 6 random rgb with reset pulse at y=2
  task automatic drive_frame(input int mode);
    logic [11:0] px;
    int          hc;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        hc = (mode == 3 && v == 1 && h == 5) ? 4 : h;
        case (mode)
          0:       px = 12'h000;
          1:       px = 12'(h);
          2:       px = (h == 3 && v == 2) ? 12'h007 : 12'(h);
          default: px = 12'($urandom);
        endcase
        @(negedge clk);
        if (mode == 6 && v == 2 && h == 1) begin
          check("rst_valid", 32'(res_valid),   32'd0);
          check("rst_frame", 32'(res_frame),   32'd0);
          check("rst_crc",   32'(res_crc),     32'd0);
          check("rst_pix",   32'(res_pix_cnt), 32'd0);
          check("rst_line",  32'(res_line_cnt), 32'd0);
        end
        rst         = (mode == 6 && v == 2 && h == 0);
        vif.hcount  = 11'(hc);
        vif.vcount  = 11'(v);
        vif.hblnk   = (h >= H_ACT) || (mode == 4 && v == 2 && h >= H_ACT - 1);
        vif.vblnk   = (v >= V_ACT);
        vif.hsync   = (h >= 9 && h < 11);
        vif.vsync   = (v == 5);
        vif.rgb     = px;
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  logic [15:0] zero_crc, ramp_crc, ramp_mod_crc;

  initial begin
    rst = 1'b1; res_ready = 1'b1;
    vif.hcount = '0; vif.vcount = '0; vif.hblnk = 1'b0; vif.vblnk = 1'b0;
    vif.hsync = 1'b0; vif.vsync = 1'b0; vif.rgb = '0;
    zero_crc = 16'hFFFF; ramp_crc = 16'hFFFF; ramp_mod_crc = 16'hFFFF;
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        zero_crc     = crc_model(zero_crc, 12'h000);
        ramp_crc     = crc_model(ramp_crc, 12'(x));
        ramp_mod_crc = crc_model(ramp_mod_crc, (x == 3 && y == 2) ? 12'h007 : 12'(x));
      end
    end
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(res_valid),   32'd0);
    check("reset_frame", 32'(res_frame),   32'd0);
    check("reset_pix",   32'(res_pix_cnt), 32'd0);

    // 1: clean frames, first partial frame dropped
    repeat (3) drive_frame(0);
    check("t1_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() >= 2) begin
      check("t1_frame0", 32'(acc_q[0].frame),     32'd0);
      check("t1_frame1", 32'(acc_q[1].frame),     32'd1);
      check("t1_pix",    32'(acc_q[0].pix_cnt),   32'd32);
      check("t1_lines",  32'(acc_q[0].line_cnt),  32'd4);
      check("t1_coord",  32'(acc_q[1].coord_err), 32'd0);
      check("t1_size",   32'(acc_q[1].size_err),  32'd0);
      check("t1_crc",    32'(acc_q[1].crc),       32'(zero_crc));
    end
    acc_q.delete();

    // 2: ramp and single-pixel change
    drive_frame(1);
    drive_frame(2);
    check("t2_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() >= 2) begin
      check("t2_crc_ramp", 32'(acc_q[0].crc), 32'(ramp_crc));
      check("t2_crc_mod",  32'(acc_q[1].crc), 32'(ramp_mod_crc));
      checks++;
      if (acc_q[0].crc == acc_q[1].crc) begin
        errors++;
        $display("FAIL t2_crc_differs actual=%04h required=!%04h", acc_q[1].crc, acc_q[0].crc);
      end
    end
    acc_q.delete();

    // 3: coordinate glitch
    drive_frame(3);
    check("t3_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) begin
      check("t3_coord", 32'(acc_q[0].coord_err), 32'd1);
      check("t3_size",  32'(acc_q[0].size_err),  32'd0);
      check("t3_pix",   32'(acc_q[0].pix_cnt),   32'd32);
      check("t3_frame", 32'(acc_q[0].frame),     32'd4);
    end
    acc_q.delete();

    // 4: short line
    drive_frame(4);
    check("t4_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) begin
      check("t4_pix",   32'(acc_q[0].pix_cnt),  32'd31);
      check("t4_size",  32'(acc_q[0].size_err), 32'd1);
      check("t4_lines", 32'(acc_q[0].line_cnt), 32'd4);
    end
    acc_q.delete();

    // 5: back-pressure across two frame ends
    res_ready = 1'b0;
    drive_frame(5);
    check("t5_valid1",   32'(res_valid),   32'd1);
    check("t5_frame1",   32'(res_frame),   32'd6);
    check("t5_overrun1", 32'(res_overrun), 32'd0);
    drive_frame(5);
    check("t5_valid2",   32'(res_valid),   32'd1);
    check("t5_frame2",   32'(res_frame),   32'd7);
    check("t5_overrun2", 32'(res_overrun), 32'd1);
    check("t5_none_acc", 32'(acc_q.size()), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_drop", 32'(res_valid), 32'd0);
    check("t5_acc", 32'(acc_q.size()), 32'd1);
    acc_q.delete();

    // 6: reset mid-frame while a result is pending
    res_ready = 1'b0;
    drive_frame(0);
    check("t6_pending", 32'(res_valid), 32'd1);
    drive_frame(6);
    res_ready = 1'b1;
    drive_frame(0);
    check("t6_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) begin
      check("t6_frame", 32'(acc_q[0].frame),   32'd0);
      check("t6_pix",   32'(acc_q[0].pix_cnt), 32'd32);
    end
    acc_q.delete();

    // randomized rgb and back-pressure, checked by the model every cycle
    rand_ready = 1'b1;
    repeat (6) drive_frame(5);
    rand_ready = 1'b0;
    res_ready  = 1'b1;
    drive_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
